// File: rtl/relm_uart_fifo.sv
// relm_uart_fifo: full-duplex 8-bit UART with TX/RX FIFOs on a ReLM push/pop port.
// Define RELM_UART_PARITY_EN for 8E1 framing; the default build is 8N1.
`timescale 1ns/1ps
module relm_uart_fifo #(
  parameter int WD     = 32,
  parameter int CLKDIV = 145,
  parameter int OVS    = 3,
  parameter int WAD    = 4
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic        uart_in,
  output logic        uart_out,
  input  logic [WD:0] d_in,
  output logic [WD:0] q_out
);

  localparam int DEPTH = 1 << WAD;
  localparam int CW    = $clog2(CLKDIV);
  localparam int TW    = $clog2(OVS);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLKDIV - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'((OVS - 1) / 2 - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef RELM_UART_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          rx_meta, rx_sync;
  logic          tx_wr_req, rx_pop_req, clr_req;
  logic          unused_cmd;

  assign tick       = (div_cnt == DIV_LAST);
  assign tx_wr_req  = d_in[WD-1];
  assign rx_pop_req = d_in[WD-2];
  assign clr_req    = d_in[WD-3];
  assign unused_cmd = ^d_in;

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in)  div_cnt <= '0;
    else if (tick)  div_cnt <= '0;
    else            div_cnt <= div_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx_sync <= rx_meta;
    end

  // ---------------- RX FIFO: extra pointer bit separates full from empty
  logic [8:0]   rx_mem [DEPTH];
  logic [WAD:0] rx_wp, rx_rp;
  logic         rx_empty, rx_full, rx_pop, rx_push, rx_wr, ovr_set, overrun;
  logic [8:0]   rx_word, rx_head;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[WAD] != rx_rp[WAD]) && (rx_wp[WAD-1:0] == rx_rp[WAD-1:0]);
  assign rx_pop   = rx_pop_req && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign ovr_set  = rx_push && rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rp[WAD-1:0]];

  always_ff @(posedge clk)
    if (rx_wr) rx_mem[rx_wp[WAD-1:0]] <= rx_word;

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      rx_wp   <= '0;
      rx_rp   <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_wr)        rx_wp <= rx_wp + 1'b1;
      if (rx_pop)       rx_rp <= rx_rp + 1'b1;
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_req) overrun <= 1'b0;
    end

  // ---------------- RX FSM
  logic [2:0]    rx_state, rx_bcnt;
  logic [TW-1:0] rx_tcnt;
  logic [7:0]    rx_shift;
`ifdef RELM_UART_PARITY_EN
  logic          rx_par_err;
  assign rx_word = {~rx_sync | rx_par_err, rx_shift};
`else
  assign rx_word = {~rx_sync, rx_shift};
`endif
  assign rx_push = tick && (rx_state == S_STOP) && (rx_tcnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      rx_state   <= S_IDLE;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_shift   <= '0;
`ifdef RELM_UART_PARITY_EN
      rx_par_err <= 1'b0;
`endif
    end else if (tick) begin
      case (rx_state)
        S_IDLE:
          if (!rx_sync) begin
            rx_state <= S_START;
            rx_tcnt  <= '0;
          end
        S_START:
          if (rx_tcnt != HALF_LAST) rx_tcnt <= rx_tcnt + 1'b1;
          else begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end
        S_DATA:
          if (rx_tcnt != BIT_LAST) rx_tcnt <= rx_tcnt + 1'b1;
          else begin
            rx_tcnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bcnt  <= rx_bcnt + 1'b1;
`ifdef RELM_UART_PARITY_EN
            if (rx_bcnt == 3'd7) rx_state <= S_PARITY;
`else
            if (rx_bcnt == 3'd7) rx_state <= S_STOP;
`endif
          end
`ifdef RELM_UART_PARITY_EN
        S_PARITY:
          if (rx_tcnt != BIT_LAST) rx_tcnt <= rx_tcnt + 1'b1;
          else begin
            rx_tcnt    <= '0;
            rx_par_err <= rx_sync ^ (^rx_shift);
            rx_state   <= S_STOP;
          end
`endif
        S_STOP:
          if (rx_tcnt != BIT_LAST) rx_tcnt <= rx_tcnt + 1'b1;
          else begin
            rx_tcnt  <= '0;
            rx_state <= rx_sync ? S_IDLE : S_WAIT_HIGH;
          end
        S_WAIT_HIGH:
          if (rx_sync) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end

  // ---------------- TX FIFO
  logic [7:0]   tx_mem [DEPTH];
  logic [WAD:0] tx_wp, tx_rp;
  logic         tx_empty, tx_full, tx_wr, tx_load;
  logic [7:0]   tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[WAD] != tx_rp[WAD]) && (tx_wp[WAD-1:0] == tx_rp[WAD-1:0]);
  assign tx_wr    = tx_wr_req && !tx_full;
  assign tx_head  = tx_mem[tx_rp[WAD-1:0]];

  always_ff @(posedge clk)
    if (tx_wr) tx_mem[tx_wp[WAD-1:0]] <= d_in[7:0];

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_wr)   tx_wp <= tx_wp + 1'b1;
      if (tx_load) tx_rp <= tx_rp + 1'b1;
    end

  // ---------------- TX FSM: a queued byte loads straight from STOP so frames run gap-free
  logic [2:0]    tx_state, tx_bcnt;
  logic [TW-1:0] tx_tcnt;
  logic [7:0]    tx_shift;
`ifdef RELM_UART_PARITY_EN
  logic          tx_par;
`endif
  assign tx_load = tick && !tx_empty &&
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_tcnt == BIT_LAST)));

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      tx_state <= S_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      uart_out <= 1'b1;
`ifdef RELM_UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_state <= S_START;
      tx_tcnt  <= '0;
      tx_shift <= tx_head;
      uart_out <= 1'b0;
`ifdef RELM_UART_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else if (tick && (tx_state != S_IDLE)) begin
      if (tx_tcnt != BIT_LAST) tx_tcnt <= tx_tcnt + 1'b1;
      else begin
        tx_tcnt <= '0;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bcnt  <= '0;
            uart_out <= tx_shift[0];
          end
          S_DATA:
            if (tx_bcnt == 3'd7) begin
`ifdef RELM_UART_PARITY_EN
              tx_state <= S_PARITY;
              uart_out <= tx_par;
`else
              tx_state <= S_STOP;
              uart_out <= 1'b1;
`endif
            end else begin
              tx_bcnt  <= tx_bcnt + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_out <= tx_shift[1];
            end
`ifdef RELM_UART_PARITY_EN
          S_PARITY: begin
            tx_state <= S_STOP;
            uart_out <= 1'b1;
          end
`endif
          default: begin
            tx_state <= S_IDLE;
            uart_out <= 1'b1;
          end
        endcase
      end
    end

  // ---------------- status word; head fields read as zero while the RX FIFO is empty
  logic [WD:0] status;

  always_comb begin
    status       = '0;
    status[WD-1] = !tx_full;
    status[WD-2] = !rx_empty;
    status[WD-3] = overrun;
    if (!rx_empty) begin
      status[WD-4] = rx_head[8];
      status[7:0]  = rx_head[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) q_out <= '0;
    else           q_out <= status;

endmodule

// File: tb/tb_relm_uart_fifo.sv
// tb_relm_uart_fifo: randomized directed bench for relm_uart_fifo against a queue-based model.
// Follows RELM_UART_PARITY_EN so frames match the DUT build.
`timescale 1ns/1ps
module tb_relm_uart_fifo;

  localparam int WD     = 32;
  localparam int CLKDIV = 4;
  localparam int OVS    = 3;
  localparam int WAD    = 4;
  localparam int DEPTH  = 1 << WAD;
  localparam int BIT    = CLKDIV * OVS;
`ifdef RELM_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        uart_in = 1'b1;
  logic        uart_out;
  logic [WD:0] d_in = '0;
  logic [WD:0] q_out;

  relm_uart_fifo #(.WD(WD), .CLKDIV(CLKDIV), .OVS(OVS), .WAD(WAD)) dut (
    .clk      (clk),
    .rst_n_in (rst_n_in),
    .uart_in  (uart_in),
    .uart_out (uart_out),
    .d_in     (d_in),
    .q_out    (q_out)
  );

  always #5 clk = ~clk;

  int         n_asserts = 0;
  int         n_fails   = 0;
  int         cyc       = 0;
  logic [7:0] tx_q[$];
  logic [8:0] rx_q[$];
  logic       ovr_m = 1'b0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit i of the result is the i-th bit on the wire: start, data LSB first, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic stop);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef RELM_UART_PARITY_EN
    f[9]   = ^b;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  function automatic logic [WD:0] status_word(input logic tx_nf);
    logic [WD:0] s;
    s       = '0;
    s[WD-1] = tx_nf;
    s[WD-2] = (rx_q.size() != 0);
    s[WD-3] = ovr_m;
    if (rx_q.size() != 0) begin
      s[WD-4] = rx_q[0][8];
      s[7:0]  = rx_q[0][7:0];
    end
    return s;
  endfunction

  // One command cycle; the model applies it at the same edge as the DUT.
  task automatic apply_stimulus(input logic wr, input logic pop, input logic clr, input logic [7:0] data);
    d_in        = '0;
    d_in[WD-1]  = wr;
    d_in[WD-2]  = pop;
    d_in[WD-3]  = clr;
    d_in[7:0]   = data;
    if (wr && tx_q.size() < DEPTH) tx_q.push_back(data);
    if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
    if (clr) ovr_m = 1'b0;
    step();
    d_in = '0;
  endtask

  task automatic tx_wait_start(input int max_wait, output logic [7:0] b);
    int w;
    w = 0;
    while (uart_out !== 1'b0 && w < max_wait) begin
      step();
      w++;
    end
    check_output("tx_start_seen", {32'd0, uart_out}, '0);
    b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
  endtask

  // Entered on the first negedge of wire bit 'first'; each bit must hold for exactly BIT clocks.
  task automatic tx_bits(input logic [7:0] b, input int first, input logic chk_nf);
    logic [10:0] f;
    logic        v0, v1;
    f = make_frame(b, 1'b1);
    for (int i = first; i < NB; i++) begin
      v0 = uart_out;
      repeat (BIT - 1) step();
      v1 = uart_out;
      check_output($sformatf("tx_bit%0d_of_%02h", i, b), {31'd0, v0, v1}, {31'd0, f[i], f[i]});
      if (chk_nf) check_output("tx_not_full", {32'd0, q_out[WD-1]}, {32'd0, 1'b1});
      step();
    end
  endtask

  task automatic tx_idle_check(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      step();
      if (uart_out !== 1'b1) lows++;
    end
    check_output(tag, lows, '0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [10:0] f;
    f = make_frame(b, stop);
    for (int i = 0; i < NB; i++) begin
      uart_in = f[i];
      repeat (BIT) step();
    end
  endtask

  task automatic rx_model_push(input logic [8:0] w);
    if (rx_q.size() < DEPTH) rx_q.push_back(w);
    else ovr_m = 1'b1;
  endtask

  initial begin
    logic [7:0] b, b0;
    int k;

    $display("[TB] start, %0d wire bits per frame", NB);

    // Reset state and first edge after release.
    repeat (3) step();
    check_output("reset_uart_out", {32'd0, uart_out}, {32'd0, 1'b1});
    check_output("reset_q_out", q_out, '0);
    rst_n_in = 1'b1;
    step();
    check_output("post_reset_status", q_out, status_word(1'b1));

    // Single TX frames: 0x55 and one random byte.
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h55);
    tx_wait_start(CLKDIV + 1, b);
    check_output("tx_byte_55", {25'd0, b}, {25'd0, 8'h55});
    tx_bits(b, 0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    tx_wait_start(CLKDIV + 1, b);
    tx_bits(b, 0, 1'b1);
    tx_idle_check("tx_idle_after_single", 2 * BIT);

    // TX burst while a frame is on the wire: DEPTH writes fit, the extra one is dropped.
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    tx_wait_start(CLKDIV + 1, b0);
    for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    step();
    k = DEPTH + 2;
    check_output("tx_full_status", q_out, status_word(tx_q.size() < DEPTH));
    while (k < 2 * BIT) begin
      step();
      k++;
    end
    tx_bits(b0, 2, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      tx_wait_start(0, b);
      tx_bits(b, 0, 1'b0);
    end
    tx_idle_check("tx_no_extra_frame", 2 * NB * BIT);
    step();
    check_output("tx_drained_status", q_out, status_word(1'b1));

    // RX 0xA3 then pop.
    send_frame(8'hA3, 1'b1);
    rx_model_push({1'b0, 8'hA3});
    repeat (2) step();
    check_output("rx_a3_status", q_out, status_word(1'b1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check_output("rx_after_pop", q_out, status_word(1'b1));

    // A few random RX frames, queued then popped in order.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      rx_model_push({1'b0, b});
      repeat ($urandom_range(0, BIT)) step();
    end
    step();
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("rx_rand_head%0d", i), q_out, status_word(1'b1));
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
      step();
    end

    // RX overrun: DEPTH+1 frames without popping, then clear and drain.
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      rx_model_push({1'b0, b});
    end
    repeat (2) step();
    check_output("rx_overrun_status", q_out, status_word(1'b1));
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check_output("rx_overrun_cleared", q_out, status_word(1'b1));
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
      step();
      if (i % 5 == 4 || i == DEPTH - 1)
        check_output($sformatf("rx_drain%0d", i), q_out, status_word(1'b1));
    end

    // Framing error: bad stop bit followed by a long break.
    b = 8'($urandom);
    send_frame(b, 1'b0);
    rx_model_push({1'b1, b});
    repeat (30 * BIT) step();
    check_output("rx_frame_err_entry", q_out, status_word(1'b1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check_output("rx_break_no_entries", q_out, status_word(1'b1));
    uart_in = 1'b1;
    repeat (3 * BIT) step();
    check_output("rx_after_line_high", q_out, status_word(1'b1));

    // Reset during data bit 3 of a TX frame whose bit 3 is 0.
    b = 8'($urandom) & 8'hF7;
    apply_stimulus(1'b1, 1'b0, 1'b0, b);
    tx_wait_start(CLKDIV + 1, b0);
    repeat (4 * BIT + BIT / 2) step();
    check_output("tx_bit3_low", {32'd0, uart_out}, '0);
    rst_n_in = 1'b0;
    #1;
    check_output("midframe_reset_uart_out", {32'd0, uart_out}, {32'd0, 1'b1});
    check_output("midframe_reset_q_out", q_out, '0);
    tx_q.delete();
    rx_q.delete();
    ovr_m = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();
    check_output("midframe_post_reset_status", q_out, status_word(1'b1));
    tx_idle_check("no_residual_frame", 2 * NB * BIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/relm_uart_fifo.md
# relm_uart_fifo

Parametrised UART peripheral for the ReLM push/pop I/O fabric: a full-duplex 8-bit serial port with a programmable bit clock, configurable oversampling, and independent TX and RX FIFOs of depth 2**WAD. It sits on one ReLM pop port, and the processor drives commands through `d_in` and reads status and data through `q_out`. It adds overrun and framing-error flags, plus an optional parity bit.

## Interface
- `WD`, 32: processor word width; port buses are WD+1 bits.
- `CLKDIV`, 145: clk cycles per sample tick (≥2).
- `OVS`, 3: sample ticks per bit (odd, ≥3).
- `WAD`, 4: log2 of the depth of each FIFO (RX and TX, 2**WAD entries each).

Ports:
- `clk`  in  1  system clock
- `rst_n_in`  in  1  asynchronous active-low reset
- `uart_in`  in  1  serial RX line, asynchronous to `clk`
- `uart_out`  out  1  serial TX line, idle high
- `d_in`  in  WD+1  command word:
  - [WD-1] TX write; data is [7:0].
  - [WD-2] RX pop.
  - [WD-3] clear error flags.
  - Other bits are ignored.
- `q_out`  out  WD+1  status word, registered:
  - [WD] = 0.
  - [WD-1] TX not full.
  - [WD-2] RX not empty.
  - [WD-3] overrun, sticky.
  - [WD-4] error bit of the RX head entry.
  - [7:0] RX head data.
  - All other bits 0.

## Operation
- **Reset:** asserting `rst_n_in` forces the following state immediately.
  - `uart_out`=1.
  - `q_out`=0.
  - Both FIFOs empty.
  - Flags cleared.
  - Tick counter, TX FSM and RX FSM return to idle.
- **Tick generator:** a counter runs 0..CLKDIV-1 and emits a one-cycle tick at CLKDIV-1. It never stops. One bit period is CLKDIV*OVS clocks.
- **RX input:** `uart_in` passes through a 2-flop synchroniser before any use.
- **RX FSM (IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH):**
  - IDLE: a low sample on a tick enters START.
  - START: after (OVS-1)/2 further ticks the line is re-sampled. High means a glitch; return to IDLE.
  - Data bits are then sampled every OVS ticks, 8 bits, LSB first.
  - STOP: the stop-bit sample is taken.
    - Low: set the entry error bit and go to WAIT_HIGH. WAIT_HIGH waits for a high sample, which handles break conditions.
    - High: return to IDLE.
  - Each completed frame pushes {err, data} into the RX FIFO.
  - If the RX FIFO is full at the push, the byte is dropped and the overrun flag is set.
- **RX pop:** pop with the RX FIFO empty is ignored. Pop and push in the same cycle on a full FIFO are both accepted, and overrun is not set.
- **TX write:** a write with the TX FIFO full is dropped silently; software polls [WD-1].
- **TX FSM (IDLE, START, DATA, [PARITY], STOP):**
  - Leaves IDLE on a tick when the TX FIFO is non-empty, and dequeues the entry at that point.
  - Each bit lasts OVS ticks.
  - Frames run back-to-back with no idle gap while data remains.
- **Clear flags:** [WD-3] clears overrun. If a new overrun occurs in the same cycle, set wins.
- **FIFO pointers:** wrap modulo 2**WAD. Full/empty are distinguished by an extra pointer bit. Usable depth is exactly 2**WAD.

## Timing
- `q_out` reflects state after the previous edge. A command at edge n is visible in `q_out` after edge n+1.
- TX latency: `uart_out` falls at the first tick after the write is registered, so at most CLKDIV+1 clocks after the write.
- RX latency: [WD-2] rises within CLKDIV+2 clocks after the stop-bit sample tick. The extra clocks cover the synchroniser plus the FIFO write.
- Line-edge uncertainty is ±1 tick. The sample point lies (OVS-1)/2 ticks into each bit, ±CLKDIV clocks.
- After reset release, [WD-1]=1 from the first edge.

## Configuration
- `RELM_UART_PARITY_EN` defined:
  - An even-parity bit follows data bit 7 in both directions; the frame is 8E1.
  - TX computes the bit as XOR of the data.
  - On RX, a parity mismatch or a bad stop bit sets the entry error bit.
- Undefined: frames are 8N1, with no PARITY state in either FSM.

## Test plan
- **TX:** CLKDIV=4, OVS=3; write 0x55.
  - `uart_out` shows start 0, bits 1,0,1,0,1,0,1,0, then stop 1, each bit 12 clocks.
  - [WD-1] stays 1.
- **TX burst:** write 2**WAD+1 bytes back-to-back.
  - [WD-1]=0 once the FIFO is full.
  - The extra byte is dropped; all other frames go out contiguously.
- **RX:** drive the 0xA3 frame at 12 clocks/bit.
  - [WD-2]=1 with [7:0]=0xA3 and [WD-4]=0.
  - After a pop, [WD-2]=0.
- **RX overrun:** send 2**WAD+1 frames without popping.
  - [WD-3]=1 and the FIFO holds the first 2**WAD bytes.
  - A clear command drops [WD-3] to 0.
- **Framing error:** send a frame whose stop bit is 0, followed by 30 low bits.
  - The entry has [WD-4]=1.
  - No further entries appear until the line returns high.
- **Reset mid-frame:** assert `rst_n_in` during TX bit 3.
  - `uart_out`=1 and `q_out`=0 immediately.
  - After release, [WD-1]=1 and no residual frame is sent.
